// File: rtl/prog_loader.sv
// Host-side loader: streams a program into instruction memory, runs the core for a
// fixed cycle count, then reads a data-memory window back out as a word stream.
module prog_loader #(
    parameter int IMEM_AW   = 9,
    parameter int DMEM_AW   = 10,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic [IMEM_AW:0]   imem_len,
    input  logic [31:0]        run_cycles,
    input  logic [31:0]        dump_base,
    input  logic [DMEM_AW:0]   dump_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [31:0]        imem_addr,
    output logic               imem_wen,
    output logic               imem_ren,
    output logic [31:0]        imem_wdata,
    output logic [31:0]        dmem_addr,
    output logic               dmem_wen,
    output logic               dmem_ren,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    output logic               cpu_enable,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    // Both streams use valid/ready: a word moves on any cycle where valid and ready are
    // both high; the sender keeps valid and data stable until that cycle.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_REQ = 3'd3,
        S_DUMP_CAP = 3'd4,
        S_DUMP_OUT = 3'd5,
        S_FIN      = 3'd6
    } state_t;

    localparam logic [31:0]      STEP    = 32'(ADDR_STEP);
    localparam logic [IMEM_AW:0] IDX_ONE = (IMEM_AW+1)'(1);
    localparam logic [DMEM_AW:0] K_ONE   = (DMEM_AW+1)'(1);

    state_t             state_q, state_d;
    logic [IMEM_AW:0]   idx_q, idx_d;
    logic [DMEM_AW:0]   k_q, k_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [IMEM_AW:0]   ilen_q, ilen_d;
    logic [31:0]        base_q, base_d;
    logic [DMEM_AW:0]   dlen_q, dlen_d;
    logic [31:0]        odata_q, odata_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            ilen_q  <= '0;
            base_q  <= '0;
            dlen_q  <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            ilen_q  <= ilen_d;
            base_q  <= base_d;
            dlen_q  <= dlen_d;
            odata_q <= odata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        ilen_d  = ilen_q;
        base_d  = base_q;
        dlen_d  = dlen_q;
        odata_d = odata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ilen_d = imem_len;
                    cnt_d  = run_cycles;
                    base_d = dump_base;
                    dlen_d = dump_len;
                    idx_d  = '0;
                    k_d    = '0;
                    // Empty phases are skipped in LOAD, RUN, DUMP order.
                    if (imem_len != '0)        state_d = S_LOAD;
                    else if (run_cycles != '0) state_d = S_RUN;
                    else if (dump_len != '0)   state_d = S_DUMP_REQ;
                    else                       state_d = S_FIN;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q + IDX_ONE == ilen_q) begin
                        if (cnt_q != '0)       state_d = S_RUN;
                        else if (dlen_q != '0) state_d = S_DUMP_REQ;
                        else                   state_d = S_FIN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) state_d = (dlen_q != '0) ? S_DUMP_REQ : S_FIN;
            end
            S_DUMP_REQ: state_d = S_DUMP_CAP;
            S_DUMP_CAP: begin
                odata_d = dmem_rdata;
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    k_d     = k_q + K_ONE;
                    state_d = (k_q + K_ONE == dlen_q) ? S_FIN : S_DUMP_REQ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_LOAD);
        imem_wen   = (state_q == S_LOAD) && in_valid;
        imem_ren   = 1'b0;
        imem_addr  = (state_q == S_LOAD) ? 32'(idx_q) * STEP : 32'd0;
        imem_wdata = imem_wen ? in_data : 32'd0;
        dmem_wen   = 1'b0;
        dmem_wdata = 32'd0;
        dmem_ren   = (state_q == S_DUMP_REQ);
        dmem_addr  = (state_q == S_DUMP_REQ) ? base_q + 32'(k_q) * STEP : 32'd0;
        cpu_enable = (state_q == S_RUN);
        out_valid  = (state_q == S_DUMP_OUT);
        out_data   = odata_q;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FIN);
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/run/dump flow, back-pressure, empty job and
// mid-run reset, with a registered data-memory model behind the dump port.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic [9:0]  imem_len;
  logic [31:0] run_cycles;
  logic [31:0] dump_base;
  logic [10:0] dump_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] imem_addr;
  logic        imem_wen;
  logic        imem_ren;
  logic [31:0] imem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic        dmem_ren;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [31:0] imem_log [0:511];
  logic [31:0] dmem [0:63];
  logic [31:0] exp_q[$];

  localparam logic [31:0] W0 = 32'h20080005;
  localparam logic [31:0] W1 = 32'h20090007;
  localparam logic [31:0] W2 = 32'h01095020;
  localparam logic [31:0] W3 = 32'hCAFEF00D;

  prog_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_len(imem_len), .run_cycles(run_cycles),
    .dump_base(dump_base), .dump_len(dump_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_ren(dmem_ren), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .cpu_enable(cpu_enable), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // activity monitors and one-cycle-latency data memory
  always @(posedge clk) begin
    if (imem_wen) begin
      wen_cnt <= wen_cnt + 1;
      imem_log[imem_addr[10:2]] <= imem_wdata;
    end
    if (dmem_ren) begin
      ren_cnt <= ren_cnt + 1;
      dmem_rdata <= dmem[dmem_addr[7:2]];
    end
    if (cpu_enable) en_cnt <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; imem_len = '0; run_cycles = '0; dump_base = '0; dump_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
  endtask

  initial begin
    int en_cycles;
    int stall_bad;
    int wen0, ren0, en0, done0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 512; i++) imem_log[i] = 32'h0;
    dmem[4] = 32'hDEADBEEF;
    dmem[5] = 32'h12345678;
    idle_inputs();
    arst_n = 1'b0;
    #3;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_imem", {imem_addr[29:0], imem_wen, imem_ren} | imem_wdata, 32'd0);
    chk("rst_dmem", {dmem_addr[29:0], dmem_wen, dmem_ren} | dmem_wdata, 32'd0);
    chk("rst_ctrl", {29'd0, cpu_enable, busy, done}, 32'd0);
    tick(); tick();
    arst_n = 1'b1;

    // full job: 3-word load with a stall, 10 run cycles, 2-word dump with back-pressure
    tick();
    imem_len = 10'd3; run_cycles = 32'd10; dump_base = 32'h10; dump_len = 11'd2; start = 1'b1;
    settle();
    chk("pre_start_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0; imem_len = 10'd0; dump_base = 32'h100; in_valid = 1'b1; in_data = W0;
    settle();
    chk("load0_ready", 32'(in_ready), 32'd1);
    chk("load0_wen", 32'(imem_wen), 32'd1);
    chk("load0_addr", imem_addr, 32'h0);
    chk("load0_wdata", imem_wdata, W0);
    tick();
    in_data = W1;
    settle();
    chk("load1_addr", imem_addr, 32'h4);
    chk("load1_wdata", imem_wdata, W1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("stall_wen", 32'(imem_wen), 32'd0);
    chk("stall_ready", 32'(in_ready), 32'd1);
    chk("stall_cpu_en", 32'(cpu_enable), 32'd0);
    tick();
    settle();
    chk("stall2_wen", 32'(imem_wen), 32'd0);
    tick();
    in_valid = 1'b1; in_data = W2;
    settle();
    chk("load2_wen", 32'(imem_wen), 32'd1);
    chk("load2_addr", imem_addr, 32'h8);
    chk("load2_wdata", imem_wdata, W2);
    tick();
    start = 1'b1;
    settle();
    chk("run_in_ready", 32'(in_ready), 32'd0);
    chk("run_wen_ignored", 32'(imem_wen), 32'd0);
    chk("run_cpu_en", 32'(cpu_enable), 32'd1);
    en_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 1'b0; in_valid = 1'b0;
      settle();
      if (!cpu_enable) break;
      en_cycles++;
    end
    chk("run_cycles", 32'(en_cycles), 32'd10);
    chk("req0_ren", 32'(dmem_ren), 32'd1);
    chk("req0_addr", dmem_addr, 32'h10);
    ren0 = ren_cnt;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    tick();
    settle();
    chk("cap0_ren", 32'(dmem_ren), 32'd0);
    chk("cap0_valid", 32'(out_valid), 32'd0);
    tick();
    settle();
    chk("out0_valid", 32'(out_valid), 32'd1);
    chk("out0_data", out_data, exp_q[0]);
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || dmem_ren !== 1'b0) stall_bad++;
    end
    chk("bp_stable", 32'(stall_bad), 32'd0);
    chk("bp_one_read", 32'(ren_cnt - ren0), 32'd1);
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    settle();
    chk("req1_ren", 32'(dmem_ren), 32'd1);
    chk("req1_addr", dmem_addr, 32'h14);
    tick();
    tick();
    settle();
    chk("out1_valid", 32'(out_valid), 32'd1);
    chk("out1_data", out_data, exp_q.pop_front());
    tick();
    settle();
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    tick();
    out_ready = 1'b0;
    settle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("job1_done_cnt", 32'(done_cnt), 32'd1);
    chk("job1_wen_cnt", 32'(wen_cnt), 32'd3);
    chk("job1_imem0", imem_log[0], W0);
    chk("job1_imem1", imem_log[1], W1);
    chk("job1_imem2", imem_log[2], W2);

    // empty job
    wen0 = wen_cnt; ren0 = ren_cnt; en0 = en_cnt; done0 = done_cnt;
    tick();
    idle_inputs();
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    settle();
    tick();
    start = 1'b0;
    settle();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd1);
    tick();
    settle();
    chk("empty_idle", {30'd0, busy, done}, 32'd0);
    chk("empty_activity", 32'((wen_cnt - wen0) + (ren_cnt - ren0) + (en_cnt - en0)), 32'd0);
    chk("empty_done_cnt", 32'(done_cnt - done0), 32'd1);

    // reset during cycle 4 of a 10-cycle run, then a clean restart
    tick();
    idle_inputs();
    imem_len = 10'd1; run_cycles = 32'd10; dump_base = 32'h14; dump_len = 11'd1; start = 1'b1;
    settle();
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = W3;
    settle();
    chk("rr_load_addr", imem_addr, 32'h0);
    tick();
    in_valid = 1'b0;
    settle();
    tick(); tick(); tick();
    chk("rr_run_en", 32'(cpu_enable), 32'd1);
    arst_n = 1'b0;
    settle();
    chk("rr_abort", {29'd0, cpu_enable, busy, in_ready}, 32'd0);
    chk("rr_state", 32'(dbg_state), 32'd0);
    tick();
    arst_n = 1'b1;
    tick();
    imem_len = 10'd2; run_cycles = 32'd2; dump_base = 32'h14; dump_len = 11'd1; start = 1'b1;
    out_ready = 1'b1;
    settle();
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = W0;
    settle();
    chk("re_load0_addr", imem_addr, 32'h0);
    chk("re_load0_wen", 32'(imem_wen), 32'd1);
    tick();
    in_data = W1;
    settle();
    chk("re_load1_addr", imem_addr, 32'h4);
    tick();
    in_valid = 1'b0;
    settle();
    chk("re_run1", 32'(cpu_enable), 32'd1);
    tick();
    settle();
    chk("re_run2", 32'(cpu_enable), 32'd1);
    tick();
    settle();
    chk("re_req_addr", dmem_addr, 32'h14);
    chk("re_req_en", {30'd0, dmem_ren, cpu_enable}, 32'd2);
    exp_q.push_back(32'h12345678);
    tick(); tick();
    settle();
    chk("re_out_data", out_data, exp_q.pop_front());
    tick();
    settle();
    chk("re_done", 32'(done), 32'd1);
    tick();
    settle();
    chk("re_idle", 32'(busy), 32'd0);
    chk("re_imem0", imem_log[0], W0);
    chk("re_imem1", imem_log[1], W1);
    chk("never_imem_ren_dmem_wen", {30'd0, imem_ren, dmem_wen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
